// File: rtl/alu_32.sv
// alu_32: registered 32-bit integer ALU for the RV32I calculator datapath.
// One result per cycle, 1-cycle latency; zero is decoded from the result register.
// Optional feature macro: ALU32_MUL_EN enables MUL (1010) and MULHU (1011).
// Without it, both codes return 32'h0 and no multiplier is built.
module alu_32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   input  logic [3:0]  alucontrol,
   input  logic [4:0]  shamt,
   output logic [31:0] aluout,
   output logic        zero
);

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SLL   = 4'b0001;
   localparam logic [3:0] OP_SLT   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_PASSB = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_SRA   = 4'b1101;

   // Signed views of the operands for SLT and SRA
   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic        [DATA_W-1:0] result_p0;

   assign a_s = signed'(srca);
   assign b_s = signed'(srcb);

`ifdef ALU32_MUL_EN
   // Full unsigned product; MUL takes the low half, MULHU the high half
   logic [2*DATA_W-1:0] prod;
   assign prod = {{DATA_W{1'b0}}, srca} * {{DATA_W{1'b0}}, srcb};
`endif

   // Operation decode; shifts use shamt only, srcb is ignored for them
   always_comb begin
      result_p0 = '0;
      case (alucontrol)
         OP_ADD:   result_p0 = srca + srcb;
         OP_SLL:   result_p0 = srca << shamt;
         OP_SLT:   result_p0 = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
         OP_SLTU:  result_p0 = {{(DATA_W-1){1'b0}}, (srca < srcb)};
         OP_XOR:   result_p0 = srca ^ srcb;
         OP_SRL:   result_p0 = srca >> shamt;
         OP_OR:    result_p0 = srca | srcb;
         OP_AND:   result_p0 = srca & srcb;
         OP_SUB:   result_p0 = srca - srcb;
         OP_PASSB: result_p0 = srcb;
         OP_SRA:   result_p0 = unsigned'(a_s >>> shamt);
`ifdef ALU32_MUL_EN
         OP_MUL:   result_p0 = prod[DATA_W-1:0];
         OP_MULHU: result_p0 = prod[2*DATA_W-1:DATA_W];
`else
         OP_MUL:   result_p0 = '0;
         OP_MULHU: result_p0 = '0;
`endif
         default:  result_p0 = '0;
      endcase
   end

   // ---- stage boundary p0 -> output register ----
   // Result register; reset wins over any operation in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) aluout <= '0;
      else        aluout <= result_p0;
   end

   assign zero = ~|aluout;

endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32: scoreboard bench for alu_32 with directed vectors.
module tb_alu_32;

   logic        clk;
   logic        rst_n;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [3:0]  alucontrol;
   logic [4:0]  shamt;
   logic [31:0] aluout;
   logic        zero;

   alu_32 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .srca       (srca),
      .srcb       (srcb),
      .alucontrol (alucontrol),
      .shamt      (shamt),
      .aluout     (aluout),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      logic        zf;
      string       name;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic issue = 1'b0;
   logic pend;
   exp_t ex;

`ifdef ALU32_MUL_EN
   localparam logic [31:0] EXP_MUL   = 32'h002109CC;
   localparam logic [31:0] EXP_MULHU = 32'hFFFFFFFE;
`else
   localparam logic [31:0] EXP_MUL   = 32'h0;
   localparam logic [31:0] EXP_MULHU = 32'h0;
`endif

   task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [4:0] s,
                        input logic [31:0] e, input string nm);
      exp_t t;
      @(negedge clk);
      rst_n      = r;
      srca       = a;
      srcb       = b;
      alucontrol = c;
      shamt      = s;
      issue      = 1'b1;
      t.val  = e;
      t.zf   = (e == 32'h0);
      t.name = nm;
      q.push_back(t);
   endtask

   // Monitor: each issued vector produces a result one edge later
   always begin
      @(posedge clk);
      pend = issue;
      #1;
      if (pend) begin
         if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_underflow: got aluout=%h, required a queued expectation", aluout);
         end else begin
            ex = q.pop_front();
            tests++;
            if (aluout !== ex.val) begin
               fails++;
               $display("FAIL %s aluout: got %h, required %h", ex.name, aluout, ex.val);
            end
            tests++;
            if (zero !== ex.zf) begin
               fails++;
               $display("FAIL %s zero: got %b, required %b", ex.name, zero, ex.zf);
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      srca       = '0;
      srcb       = '0;
      alucontrol = '0;
      shamt      = '0;

      // Reset with live inputs: result must be 0
      drive(1'b0, 32'hDEADBEEF, 32'h12345678, 4'b0000, 5'd3, 32'h0, "reset0");
      drive(1'b0, 32'h00000234, 32'h00000EFF, 4'b0110, 5'd7, 32'h0, "reset1");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0000, 5'd0, 32'h00001133, "add");

      // SUB
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1000, 5'd0, 32'hFFFFF335, "sub_wrap");
      drive(1'b1, 32'h12345678, 32'h12345678, 4'b1000, 5'd0, 32'h0, "sub_zero");

      // Compares
      drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 5'd0, 32'h1, "slt_neg");
      drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b0011, 5'd0, 32'h0, "sltu_big");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0010, 5'd0, 32'h1, "slt_pos");
      drive(1'b1, 32'h00000001, 32'hFFFFFFFF, 4'b0011, 5'd0, 32'h1, "sltu_small");

      // Shifts (srcb varied to show it is ignored)
      drive(1'b1, 32'h80000000, 32'h00000000, 4'b1101, 5'd4,  32'hF8000000, "sra");
      drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 4'b1101, 5'd4,  32'hF8000000, "sra_b");
      drive(1'b1, 32'h70000000, 32'h0000001F, 4'b1101, 5'd4,  32'h07000000, "sra_pos");
      drive(1'b1, 32'h80000000, 32'h00000000, 4'b0101, 5'd4,  32'h08000000, "srl");
      drive(1'b1, 32'h80000000, 32'h0000001F, 4'b0101, 5'd4,  32'h08000000, "srl_b");
      drive(1'b1, 32'h00000001, 32'h00000000, 4'b0001, 5'd31, 32'h80000000, "sll31");
      drive(1'b1, 32'h00000001, 32'h00000002, 4'b0001, 5'd31, 32'h80000000, "sll31_b");
      drive(1'b1, 32'h00000234, 32'h00000005, 4'b0001, 5'd0,  32'h00000234, "sll0");
      drive(1'b1, 32'h80000000, 32'h00000005, 4'b1101, 5'd0,  32'h80000000, "sra0");
      drive(1'b1, 32'h80000000, 32'h00000005, 4'b0101, 5'd0,  32'h80000000, "srl0");

      // Logic, pass, unused codes
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0111, 5'd0, 32'h00000234, "and");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0110, 5'd0, 32'h00000EFF, "or");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0100, 5'd0, 32'h00000CCB, "xor");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1001, 5'd0, 32'h00000EFF, "passb");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1111, 5'd0, 32'h0, "op1111");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1100, 5'd0, 32'h0, "op1100");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1110, 5'd0, 32'h0, "op1110");

      // Multiply (value depends on build)
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b1010, 5'd0, EXP_MUL, "mul");
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1011, 5'd0, EXP_MULHU, "mulhu");

      // Reset mid-stream discards the operation, then resume
      drive(1'b0, 32'h00000234, 32'h00000EFF, 4'b0110, 5'd0, 32'h0, "reset_mid");
      drive(1'b1, 32'h00000234, 32'h00000EFF, 4'b0000, 5'd0, 32'h00001133, "add_after");

      @(negedge clk);
      issue = 1'b0;

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending results, required 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
